// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mips_pkg
//  Brief   : Shared MIPS core constants. Opcode and funct codes are used by
//            control. The NOP word and the fetch state encoding are used by
//            the IF stage.
//  Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;   // bltz lives here (rt = 0)
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FUNCT_JR  = 6'h08;
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;

   // sll r0,r0,0: architecturally a no-op, used to fill pipeline bubbles
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_stage_if
//  Brief   : Instruction-memory request/ready handshake between the IF stage
//            (master) and the instruction memory (slave).
//  Rev     : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ready, input imem_rdata);
   modport slave  (input  imem_req, input imem_addr,
                   output imem_ready, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_target_sel.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_target_sel
//  Brief   : Decodes the delayed jump/branch flags from control into a
//            redirect request. It also computes the new fetch target (j, jr
//            or a taken bltz). The target is always word aligned.
//  Rev     : 1.0  initial release
// ============================================================================
module fetch_target_sel (
   input  wire logic        jump_i,
   input  wire logic        branch_i,
   input  wire logic        branch_cond_i,
   input  wire logic [31:0] reg_target_i,
   input  wire logic [25:0] target_inst_i,
   input  wire logic [15:0] br_offset_i,
   input  wire logic [31:0] br_pc_plus4_i,
   output logic             redirect_o,
   output logic [31:0]      target_o
);

   logic [31:0] w_j_target;
   logic [31:0] w_br_target;

   // j keeps the upper PC nibble of the delay slot; bltz is PC+4 relative
   assign w_j_target  = {br_pc_plus4_i[31:28], target_inst_i, 2'b00};
   assign w_br_target = br_pc_plus4_i + {{14{br_offset_i[15]}}, br_offset_i, 2'b00};

   // Priority decode: jump+branch encodes jr, jump alone is j, branch needs its condition
   always_comb begin
      redirect_o = 1'b0;
      target_o   = 32'h0;
      if (jump_i && branch_i) begin
         redirect_o = 1'b1;
         target_o   = {reg_target_i[31:2], 2'b00};
      end else if (jump_i) begin
         redirect_o = 1'b1;
         target_o   = w_j_target;
      end else if (branch_i && branch_cond_i) begin
         redirect_o = 1'b1;
         target_o   = {w_br_target[31:2], 2'b00};
      end
   end

endmodule
`default_nettype wire

// File: rtl/register_cell.sv
`default_nettype none
// ============================================================================
//  Module  : register_cell
//  Brief   : Plain resettable D flop. This is the shared storage cell for
//            single-bit pipeline state.
//  Rev     : 1.0  initial release
// ============================================================================
module register_cell #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [WIDTH-1:0] d_i,
   output logic      [WIDTH-1:0] q_o
);

   // Capture d every cycle; synchronous reset to RST_VAL
   always_ff @(posedge clk) begin
      if (rst) q_o <= RST_VAL;
      else     q_o <= d_i;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_stage
//  Brief   : IF stage. Owns the PC and issues one word fetch at a time on the
//            imem handshake. It applies j/jr/bltz redirects and fills the
//            IF/ID register. A one-entry skid catches a word that returns
//            while decode is stalled.
//  Rev     : 1.0  initial release
// ============================================================================
module fetch_stage import mips_pkg::*; #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = MIPS_NOP
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        stall,
   input  wire logic        jump_del,
   input  wire logic        branch_del,
   input  wire logic        branch_cond,
   input  wire logic [31:0] reg_target,
   input  wire logic [25:0] target_inst,
   input  wire logic [15:0] br_offset,
   input  wire logic [31:0] br_pc_plus4,
   fetch_stage_if.master    imem,
   output logic [31:0]      if_instruction,
   output logic [31:0]      if_pc_plus4,
   output logic             if_valid
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_REQ  = REQ;
   localparam logic [1:0] S_DROP = DROP;
   localparam logic [1:0] S_HOLD = HOLD;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q,    pc_d;
   logic [31:0] tgt_q,   tgt_d;     // redirect target parked while a fetch drains
   logic [31:0] skid_q,  skid_d;    // word that returned during a stall
   logic [31:0] inst_q,  inst_d;
   logic [31:0] pc4_q,   pc4_d;
   logic        valid_q, valid_d;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;

   fetch_target_sel u_target_sel (
      .jump_i        (jump_del),
      .branch_i      (branch_del),
      .branch_cond_i (branch_cond),
      .reg_target_i  (reg_target),
      .target_inst_i (target_inst),
      .br_offset_i   (br_offset),
      .br_pc_plus4_i (br_pc_plus4),
      .redirect_o    (w_redirect),
      .target_o      (w_target)
   );

   assign w_pc_plus4     = pc_q + 32'd4;
   // PC only moves when a request completes, so the address is stable while waiting
   assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
   assign imem.imem_addr = pc_q;

   assign if_instruction = inst_q;
   assign if_pc_plus4    = pc4_q;
   assign if_valid       = valid_q;

   // Next-state logic: redirect first (it flushes even under stall), then sequential fetch
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      skid_d  = skid_q;
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;

      if (w_redirect) begin
         inst_d  = NOP_INST;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
         skid_d  = 32'h0;
         case (state_q)
            S_REQ, S_DROP: begin
               if (imem.imem_ready) begin
                  pc_d    = w_target;
                  state_d = S_REQ;
               end else begin
                  tgt_d   = w_target;
                  state_d = S_DROP;
               end
            end
            default: begin
               pc_d    = w_target;
               state_d = S_REQ;
            end
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_REQ;
               if (!stall) begin
                  inst_d  = NOP_INST;
                  pc4_d   = 32'h0;
                  valid_d = 1'b0;
               end
            end
            S_REQ: begin
               if (imem.imem_ready && !stall) begin
                  inst_d  = imem.imem_rdata;
                  pc4_d   = w_pc_plus4;
                  valid_d = 1'b1;
                  pc_d    = w_pc_plus4;
               end else if (imem.imem_ready) begin
                  skid_d  = imem.imem_rdata;
                  state_d = S_HOLD;
               end else if (!stall) begin
                  inst_d  = NOP_INST;
                  pc4_d   = 32'h0;
                  valid_d = 1'b0;
               end
            end
            S_DROP: begin
               if (imem.imem_ready) begin
                  pc_d    = tgt_q;
                  state_d = S_REQ;
               end
               if (!stall) begin
                  inst_d  = NOP_INST;
                  pc4_d   = 32'h0;
                  valid_d = 1'b0;
               end
            end
            default: begin  // S_HOLD
               if (!stall) begin
                  inst_d  = skid_q;
                  pc4_d   = w_pc_plus4;
                  valid_d = 1'b1;
                  pc_d    = w_pc_plus4;
                  state_d = S_REQ;
               end
            end
         endcase
      end
   end

   // State, PC, skid and IF/ID data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= 32'h0;
         skid_q  <= 32'h0;
         inst_q  <= NOP_INST;
         pc4_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         skid_q  <= skid_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
      end
   end

   register_cell #(.WIDTH(1), .RST_VAL(1'b0)) u_valid_reg (
      .clk (clk),
      .rst (rst),
      .d_i (valid_d),
      .q_o (valid_q)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fetch_stage
//  Brief   : Bench for fetch_stage. It runs directed scenarios, then a random
//            mix of stalls, redirects, slow memory and resets. Every cycle is
//            checked against a transaction-level model of the fetch unit.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] C_NOP = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        jump_del;
   logic        branch_del;
   logic        branch_cond;
   logic [31:0] reg_target;
   logic [25:0] target_inst;
   logic [15:0] br_offset;
   logic [31:0] br_pc_plus4;
   logic [31:0] if_instruction;
   logic [31:0] if_pc_plus4;
   logic        if_valid;

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(32'h0), .NOP_INST(C_NOP)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .jump_del       (jump_del),
      .branch_del     (branch_del),
      .branch_cond    (branch_cond),
      .reg_target     (reg_target),
      .target_inst    (target_inst),
      .br_offset      (br_offset),
      .br_pc_plus4    (br_pc_plus4),
      .imem           (bus.master),
      .if_instruction (if_instruction),
      .if_pc_plus4    (if_pc_plus4),
      .if_valid       (if_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks;
   int unsigned n_errors;

   // Reference model: fetch unit seen as "where am I fetching, what is parked"
   logic [31:0] m_pc;
   bit          m_fresh;       // no request issued since reset
   bit          m_skid_full;
   logic [31:0] m_skid;
   bit          m_drop;        // current fetch is wrong-path, go to m_drop_tgt after
   logic [31:0] m_drop_tgt;
   logic [31:0] e_inst;
   logic [31:0] e_pc4;
   bit          e_valid;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEAD_0001;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      m_pc        = 32'h0;
      m_fresh     = 1'b1;
      m_skid_full = 1'b0;
      m_skid      = 32'h0;
      m_drop      = 1'b0;
      m_drop_tgt  = 32'h0;
      e_inst      = C_NOP;
      e_pc4       = 32'h0;
      e_valid     = 1'b0;
   endtask

   task automatic bubble();
      e_inst  = C_NOP;
      e_pc4   = 32'h0;
      e_valid = 1'b0;
   endtask

   task automatic deliver(input logic [31:0] word);
      e_inst  = word;
      e_pc4   = m_pc + 32'd4;
      e_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
   endtask

   task automatic model_step();
      bit          redir;
      logic [31:0] tgt;
      int          off;
      bit          rdy;
      if (rst) begin
         model_reset();
         return;
      end
      rdy   = bus.imem_ready;
      redir = 1'b0;
      tgt   = 32'h0;
      off   = $signed(br_offset);
      if (jump_del && branch_del) begin
         redir = 1'b1;
         tgt   = reg_target;
      end else if (jump_del) begin
         redir = 1'b1;
         tgt   = (br_pc_plus4 & 32'hF000_0000) | ({6'd0, target_inst} << 2);
      end else if (branch_del && branch_cond) begin
         redir = 1'b1;
         tgt   = br_pc_plus4 + 32'(off * 4);
      end
      tgt = tgt & ~32'd3;

      if (redir) begin
         bubble();
         if (m_fresh || m_skid_full) begin
            m_fresh     = 1'b0;
            m_skid_full = 1'b0;
            m_pc        = tgt;
         end else if (rdy) begin
            m_pc   = tgt;
            m_drop = 1'b0;
         end else begin
            m_drop     = 1'b1;
            m_drop_tgt = tgt;
         end
      end else if (m_fresh) begin
         m_fresh = 1'b0;
         if (!stall) bubble();
      end else if (m_skid_full) begin
         if (!stall) begin
            deliver(m_skid);
            m_skid_full = 1'b0;
         end
      end else if (m_drop) begin
         if (rdy) begin
            m_pc   = m_drop_tgt;
            m_drop = 1'b0;
         end
         if (!stall) bubble();
      end else if (rdy && !stall) begin
         deliver(bus.imem_rdata);
      end else if (rdy) begin
         m_skid_full = 1'b1;
         m_skid      = bus.imem_rdata;
      end else if (!stall) begin
         bubble();
      end
   endtask

   task automatic compare();
      bit e_req;
      e_req = !m_fresh && !m_skid_full;
      check_eq("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
      if (e_req) check_eq("imem_addr", bus.imem_addr, m_pc);
      check_eq("if_valid", {31'd0, if_valid}, {31'd0, e_valid});
      check_eq("if_instruction", if_instruction, e_inst);
      if (e_valid) check_eq("if_pc_plus4", if_pc_plus4, e_pc4);
   endtask

   // One clock: present memory data for the current address, advance model, check outputs
   task automatic tick();
      bus.imem_rdata = mem_word(bus.imem_addr);
      #1;
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic no_redirect();
      jump_del    = 1'b0;
      branch_del  = 1'b0;
      branch_cond = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      stall = 1'b0;
      no_redirect();
      reg_target = 32'h0;
      target_inst = 26'h0;
      br_offset = 16'h0;
      br_pc_plus4 = 32'h0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'h0;
      model_reset();
      @(negedge clk);

      // Reset state
      tick();
      tick();
      check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
      check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_inst", if_instruction, C_NOP);

      // Sequential fetch with ready tied high
      rst = 1'b0;
      tick();
      check_eq("first_addr", bus.imem_addr, 32'h0);
      tick();
      check_eq("seq_addr4", bus.imem_addr, 32'h4);
      check_eq("seq_valid", {31'd0, if_valid}, 32'd1);
      tick();

      // Slow memory on 0x8
      bus.imem_ready = 1'b0;
      repeat (3) tick();
      check_eq("wait_addr", bus.imem_addr, 32'h8);
      check_eq("wait_valid", {31'd0, if_valid}, 32'd0);
      bus.imem_ready = 1'b1;
      tick();
      check_eq("after_wait_addr", bus.imem_addr, 32'hC);
      tick();

      // Stall on the ready cycle of 0x10
      stall = 1'b1;
      tick();
      check_eq("hold_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
      stall = 1'b0;
      tick();
      check_eq("skid_inst", if_instruction, 32'hDEAD_0001);
      check_eq("skid_pc4", if_pc_plus4, 32'h14);

      // j
      jump_del = 1'b1;
      target_inst = 26'h40;
      br_pc_plus4 = 32'h1000_0008;
      tick();
      check_eq("j_addr", bus.imem_addr, 32'h1000_0100);
      check_eq("j_flush", {31'd0, if_valid}, 32'd0);

      // jr with misaligned register value
      branch_del = 1'b1;
      reg_target = 32'h0000_2003;
      tick();
      check_eq("jr_addr", bus.imem_addr, 32'h2000);

      // bltz taken, backwards by one word
      jump_del = 1'b0;
      branch_cond = 1'b1;
      br_offset = 16'hFFFF;
      br_pc_plus4 = 32'h24;
      tick();
      check_eq("bltz_addr", bus.imem_addr, 32'h20);
      branch_cond = 1'b0;
      tick();
      check_eq("bltz_nt_addr", bus.imem_addr, 32'h24);

      // Land on 0x40, then redirect while its fetch is outstanding
      branch_cond = 1'b1;
      br_offset = 16'h0;
      br_pc_plus4 = 32'h40;
      tick();
      bus.imem_ready = 1'b0;
      jump_del = 1'b1;
      branch_del = 1'b1;
      reg_target = 32'h3000;
      tick();
      check_eq("drop_addr", bus.imem_addr, 32'h40);
      no_redirect();
      tick();
      bus.imem_ready = 1'b1;
      tick();
      check_eq("drop_next", bus.imem_addr, 32'h3000);
      check_eq("drop_valid", {31'd0, if_valid}, 32'd0);

      // Redirect together with stall: redirect wins
      stall = 1'b1;
      jump_del = 1'b1;
      branch_del = 1'b1;
      reg_target = 32'h4003;
      tick();
      check_eq("stall_redir", bus.imem_addr, 32'h4000);
      stall = 1'b0;
      no_redirect();

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         int unsigned r;
         rst = ($urandom_range(0, 299) == 0);
         stall = ($urandom_range(0, 3) == 0);
         bus.imem_ready = ($urandom_range(0, 2) != 0);
         reg_target = $urandom;
         target_inst = 26'($urandom);
         br_offset = 16'($urandom);
         br_pc_plus4 = $urandom;
         branch_cond = 1'($urandom);
         r = $urandom_range(0, 11);
         jump_del = (r == 0) || (r == 1);
         branch_del = (r == 1) || (r == 2) || (r == 3);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
